// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Main control FSM and ALU decoder for a multi-cycle MIPS datapath. Each
//   instruction is sequenced through fetch, decode, execute, memory and
//   writeback states. All outputs are Moore (decoded from the registered
//   state) except pcen, which also depends on the current-cycle zero flag.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-low; forces FETCH, gates all writes
//   op         in   [5:0] instr[31:26]
//   funct      in   [5:0] instr[5:0]
//   zero       in   ALU zero flag, current cycle
//   pcen       out  PC register enable
//   irwrite    out  instruction register enable
//   regwrite   out  register file write enable
//   memwrite   out  memory write strobe
//   alusrca    out  0=pc, 1=A
//   iord       out  0=pc, 1=aluout as memory address
//   memtoreg   out  0=aluout, 1=memory data
//   regdst     out  0=rt, 1=rd
//   alusrcb    out  [1:0] 00=B, 01=4, 10=signimm, 11=signimm<<2
//   pcsrc      out  [1:0] 00=aluresult, 01=aluout, 10=jump target
//   alucontrol out  [2:0] 010 add, 110 sub, 000 and, 001 or, 111 slt
//   state      out  [3:0] current state encoding (debug/verification)
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BEQ    = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    BNE    = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e state_q, state_d;
  state_e dec_state;
  logic   pcwrite, branch, branchne;
  logic   irwrite_d, regwrite_d, memwrite_d;

  function automatic logic [2:0] alu_decode(input logic [5:0] f);
    case (f)
      6'b100000: alu_decode = ALU_ADD;
      6'b100010: alu_decode = ALU_SUB;
      6'b100100: alu_decode = ALU_AND;
      6'b100101: alu_decode = ALU_OR;
      6'b101010: alu_decode = ALU_SLT;
      default:   alu_decode = ALU_ADD;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // its input before any of them update; reset here is synchronous.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // While reset is held the mux selects decode as FETCH, even if the register
  // still holds a mid-instruction state before the next edge.
  assign dec_state = reset ? state_q : FETCH;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    state_d    = FETCH;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branchne   = 1'b0;
    irwrite_d  = 1'b0;
    regwrite_d = 1'b0;
    memwrite_d = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;

    case (dec_state)
      DECODE: begin
        alusrcb = 2'b11;  // precompute branch target into aluout
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXEC;
          OP_BEQ:       state_d = BEQ;
          OP_BNE:       state_d = BNE;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;  // unknown op retires as a NOP
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_d = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_d = 1'b1;
      end
      EXEC: begin
        alusrca    = 1'b1;
        alucontrol = alu_decode(funct);
        state_d    = ALUWB;
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite_d = 1'b1;
      end
      BEQ: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
      end
      BNE: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branchne   = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: regwrite_d = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      // FETCH, and the unreachable encodings 13-15 recover through FETCH.
      default: begin
        alusrcb   = 2'b01;
        irwrite_d = 1'b1;
        pcwrite   = 1'b1;
        state_d   = DECODE;
      end
    endcase
  end

  assign pcen     = reset & (pcwrite | (branch & zero) | (branchne & ~zero));
  assign irwrite  = reset & irwrite_d;
  assign regwrite = reset & regwrite_d;
  assign memwrite = reset & memwrite_d;
  assign state    = state_q;

endmodule
